escape_code_lock: RTL and testbench
===================================

Name: escape_code_lock

Overview:
- Parametrised keypad/switch combination-lock puzzle engine for the escape-room design.
- Collects a sequence of CODE_LEN digits and compares them against a loadable secret.
- Grants unlock on a match; counts failed attempts and enforces a timed lockout after MAX_ATTEMPTS failures.
- Sits between the debounced KEY/SW/PS2 input decoders and the HEX/LEDR status logic. One instance exists per puzzle station.

Parameters:
- DIGIT_W, 4: bits per digit.
- CODE_LEN, 4: number of digits per code; must be >= 1.
- MAX_ATTEMPTS, 3: failed attempts allowed before lockout; must be >= 1.
- LOCKOUT_CYCLES, 250000000: lockout duration in clock cycles (5 s at 50 MHz); must be >= 1.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- digit_valid  in  1  single-cycle strobe; digit is valid.
- digit  in  DIGIT_W  entered digit value.
- clear  in  1  single-cycle strobe; discard the partial entry.
- load_secret  in  1  single-cycle strobe; latch secret_in.
- secret_in  in  CODE_LEN*DIGIT_W  new secret; digit i occupies [i*DIGIT_W +: DIGIT_W].
- relock  in  1  single-cycle strobe; return from UNLOCKED to ENTRY.
- unlocked  out  1  high while in UNLOCKED.
- locked_out  out  1  high while in LOCKOUT.
- fail_pulse  out  1  one-cycle pulse on each wrong code.
- attempts_left  out  $clog2(MAX_ATTEMPTS+1)  remaining tries.
- entry_count  out  $clog2(CODE_LEN+1)  digits entered so far.
- entry_buf  out  CODE_LEN*DIGIT_W  digits entered so far, same layout as secret_in; unfilled slots are 0.

Behaviour:
- Reset (async, reset_n low):
  - state = ENTRY
  - unlocked, locked_out, fail_pulse = 0
  - attempts_left = MAX_ATTEMPTS
  - entry_count = 0, entry_buf = 0, secret register = 0, lockout timer = 0
  - Reset asserted mid-operation aborts any state immediately.
- States: ENTRY, CHECK, UNLOCKED, LOCKOUT. All outputs are registered.
- Priority per cycle: load_secret > clear > relock > digit_valid.
- load_secret (any state):
  - latches secret_in
  - forces state = ENTRY
  - clears entry_buf and entry_count
  - sets attempts_left = MAX_ATTEMPTS and drops unlocked/locked_out on the next edge
  - a digit_valid in the same cycle is dropped.
- ENTRY:
  - digit_valid writes digit into slot entry_count and increments entry_count.
  - If the accepted digit is number CODE_LEN (entry_count was CODE_LEN-1), next state = CHECK.
  - clear zeroes entry_buf and entry_count; a same-cycle digit_valid is dropped.
- CHECK (exactly 1 cycle; digit_valid and clear are ignored):
  - Match: next state = UNLOCKED, unlocked = 1, attempts_left = MAX_ATTEMPTS.
  - Mismatch: fail_pulse = 1 for one cycle and attempts_left decrements.
    - If attempts_left was 1: next state = LOCKOUT, locked_out = 1, timer = LOCKOUT_CYCLES-1, attempts_left = 0.
    - Otherwise: next state = ENTRY.
  - In all cases entry_buf and entry_count clear.
- Latency: last digit sampled at edge t -> CHECK after edge t -> unlocked / fail_pulse / locked_out visible after edge t+1.
- LOCKOUT:
  - digit_valid, clear and relock are ignored.
  - Timer decrements each cycle.
  - In the cycle the timer is 0: next state = ENTRY, locked_out = 0, attempts_left = MAX_ATTEMPTS.
  - locked_out is high for exactly LOCKOUT_CYCLES cycles.
- UNLOCKED:
  - Holds until relock; digits are ignored.
  - relock -> ENTRY, unlocked = 0, attempts_left = MAX_ATTEMPTS.
- relock outside UNLOCKED has no effect.
- fail_pulse is never high for two consecutive cycles.
- Comparison is a full-width equality of entry_buf against the secret register.

Test Plan:
- Secret 16'h4321 loaded; enter digits 1,2,3,4 on consecutive cycles -> entry_count steps 1..4 then clears to 0; unlocked = 1 two edges after digit 4; attempts_left = 3.
- Same secret; enter 1,2,3,5 -> one fail_pulse, attempts_left = 2, state ENTRY, unlocked = 0; then enter 1,2,3,4 -> unlocked = 1, attempts_left = 3.
- LOCKOUT_CYCLES = 8; three wrong codes -> third fail_pulse coincides with locked_out rising and attempts_left = 0; locked_out high exactly 8 cycles; digits during lockout do not change entry_count; afterwards attempts_left = 3.
- Enter 1,2, then clear asserted together with digit_valid = 1 (digit 3) -> entry_count = 0, entry_buf = 0; then 1,2,3,4 -> unlocked.
- While UNLOCKED, pulse relock -> unlocked = 0, ENTRY; load_secret with 16'h9999 mid-entry (after 2 digits) -> entry_count = 0; old code 1,2,3,4 now fails; 9,9,9,9 unlocks.
- Assert reset_n low during LOCKOUT (timer mid-count) -> outputs asynchronously return to reset values (locked_out = 0, attempts_left = 3, secret = 0); entering 0,0,0,0 then unlocks.

Source files
------------

// File: rtl/escape_code_lock.sv
`default_nettype none
// ============================================================================
//  Module   : escape_code_lock
//  Purpose  : Combination-lock puzzle engine. Collects CODE_LEN digits,
//             compares them against a loadable secret, grants unlock on a
//             match, counts failed attempts and enforces a timed lockout
//             after MAX_ATTEMPTS consecutive failures.
//  Revision : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLOCK_50      in   1                      system clock, rising edge
//    reset_n       in   1                      asynchronous active-low reset
//    digit_valid   in   1                      strobe: digit is valid
//    digit         in   DIGIT_W                entered digit value
//    clear         in   1                      strobe: discard partial entry
//    load_secret   in   1                      strobe: latch secret_in
//    secret_in     in   CODE_LEN*DIGIT_W       new secret, digit i at [i*DIGIT_W +: DIGIT_W]
//    relock        in   1                      strobe: UNLOCKED -> ENTRY
//    unlocked      out  1                      high while UNLOCKED
//    locked_out    out  1                      high while LOCKOUT
//    fail_pulse    out  1                      one-cycle pulse per wrong code
//    attempts_left out  $clog2(MAX_ATTEMPTS+1) remaining tries
//    entry_count   out  $clog2(CODE_LEN+1)     digits entered so far
//    entry_buf     out  CODE_LEN*DIGIT_W       digits entered so far
// ============================================================================
module escape_code_lock #(
    parameter int DIGIT_W        = 4,
    parameter int CODE_LEN       = 4,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 250000000
) (
    input  logic                                CLOCK_50,
    input  logic                                reset_n,
    input  logic                                digit_valid,
    input  logic [DIGIT_W-1:0]                  digit,
    input  logic                                clear,
    input  logic                                load_secret,
    input  logic [CODE_LEN*DIGIT_W-1:0]         secret_in,
    input  logic                                relock,
    output logic                                unlocked,
    output logic                                locked_out,
    output logic                                fail_pulse,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   attempts_left,
    output logic [$clog2(CODE_LEN+1)-1:0]       entry_count,
    output logic [CODE_LEN*DIGIT_W-1:0]         entry_buf
);

    localparam int c_AW = $clog2(MAX_ATTEMPTS + 1);
    localparam int c_CW = $clog2(CODE_LEN + 1);
    localparam int c_SW = CODE_LEN * DIGIT_W;
    // Timer only needs to hold LOCKOUT_CYCLES-1; keep at least one bit.
    localparam int c_TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ENTRY    = 2'd0,
        CHECK    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

    state_t            r_state;
    logic [c_SW-1:0]   r_secret;
    logic [c_SW-1:0]   r_entry_buf;
    logic [c_CW-1:0]   r_entry_count;
    logic [c_AW-1:0]   r_attempts;
    logic [c_TW-1:0]   r_timer;
    logic              r_unlocked;
    logic              r_locked_out;
    logic              r_fail_pulse;

    logic              w_match;

    assign w_match = (r_entry_buf == r_secret);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ENTRY;
            r_secret      <= '0;
            r_entry_buf   <= '0;
            r_entry_count <= '0;
            r_attempts    <= c_AW'(MAX_ATTEMPTS);
            r_timer       <= '0;
            r_unlocked    <= 1'b0;
            r_locked_out  <= 1'b0;
            r_fail_pulse  <= 1'b0;
        end else begin
            // fail_pulse is only ever set from CHECK, which lasts one cycle,
            // so defaulting it low guarantees a single-cycle pulse.
            r_fail_pulse <= 1'b0;

            if (load_secret) begin
                // Highest priority, valid from any state.
                r_secret      <= secret_in;
                r_state       <= ENTRY;
                r_entry_buf   <= '0;
                r_entry_count <= '0;
                r_attempts    <= c_AW'(MAX_ATTEMPTS);
                r_timer       <= '0;
                r_unlocked    <= 1'b0;
                r_locked_out  <= 1'b0;
            end else begin
                case (r_state)
                    ENTRY: begin
                        if (clear) begin
                            r_entry_buf   <= '0;
                            r_entry_count <= '0;
                        end else if (digit_valid) begin
                            for (int i = 0; i < CODE_LEN; i++) begin
                                if (r_entry_count == c_CW'(i)) begin
                                    r_entry_buf[i*DIGIT_W +: DIGIT_W] <= digit;
                                end
                            end
                            r_entry_count <= r_entry_count + c_CW'(1);
                            if (r_entry_count == c_CW'(CODE_LEN - 1)) begin
                                r_state <= CHECK;
                            end
                        end
                    end

                    CHECK: begin
                        r_entry_buf   <= '0;
                        r_entry_count <= '0;
                        if (w_match) begin
                            r_state    <= UNLOCKED;
                            r_unlocked <= 1'b1;
                            r_attempts <= c_AW'(MAX_ATTEMPTS);
                        end else begin
                            r_fail_pulse <= 1'b1;
                            r_attempts   <= r_attempts - c_AW'(1);
                            if (r_attempts == c_AW'(1)) begin
                                r_state      <= LOCKOUT;
                                r_locked_out <= 1'b1;
                                r_timer      <= c_TW'(LOCKOUT_CYCLES - 1);
                            end else begin
                                r_state <= ENTRY;
                            end
                        end
                    end

                    UNLOCKED: begin
                        if (relock) begin
                            r_state    <= ENTRY;
                            r_unlocked <= 1'b0;
                            r_attempts <= c_AW'(MAX_ATTEMPTS);
                        end
                    end

                    LOCKOUT: begin
                        // Timer loaded with N-1 and leaves on 0: N cycles high.
                        if (r_timer == '0) begin
                            r_state      <= ENTRY;
                            r_locked_out <= 1'b0;
                            r_attempts   <= c_AW'(MAX_ATTEMPTS);
                        end else begin
                            r_timer <= r_timer - c_TW'(1);
                        end
                    end

                    default: r_state <= ENTRY;
                endcase
            end
        end
    end

    assign unlocked      = r_unlocked;
    assign locked_out    = r_locked_out;
    assign fail_pulse    = r_fail_pulse;
    assign attempts_left = r_attempts;
    assign entry_count   = r_entry_count;
    assign entry_buf     = r_entry_buf;

endmodule
`default_nettype wire

// File: tb/tb_escape_code_lock.sv
`default_nettype none
// ============================================================================
//  Module   : tb_escape_code_lock
//  Purpose  : Directed self-checking bench for escape_code_lock
//             (DIGIT_W=4, CODE_LEN=4, MAX_ATTEMPTS=3, LOCKOUT_CYCLES=8).
//  Revision : 1.0  - initial release
// ============================================================================
module tb_escape_code_lock;

    logic        clk;
    logic        reset_n;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        clear;
    logic        load_secret;
    logic [15:0] secret_in;
    logic        relock;
    logic        unlocked;
    logic        locked_out;
    logic        fail_pulse;
    logic [1:0]  attempts_left;
    logic [2:0]  entry_count;
    logic [15:0] entry_buf;

    int n_cmp  = 0;
    int n_fail = 0;

    escape_code_lock #(
        .DIGIT_W        (4),
        .CODE_LEN       (4),
        .MAX_ATTEMPTS   (3),
        .LOCKOUT_CYCLES (8)
    ) u_dut (
        .CLOCK_50      (clk),
        .reset_n       (reset_n),
        .digit_valid   (digit_valid),
        .digit         (digit),
        .clear         (clear),
        .load_secret   (load_secret),
        .secret_in     (secret_in),
        .relock        (relock),
        .unlocked      (unlocked),
        .locked_out    (locked_out),
        .fail_pulse    (fail_pulse),
        .attempts_left (attempts_left),
        .entry_count   (entry_count),
        .entry_buf     (entry_buf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        tick();
        digit_valid = 1'b0;
    endtask

    task automatic test_reset();
        if (unlocked !== 1'b0) begin $display("FAIL rst_unlocked: got %b required 0", unlocked); n_fail++; end n_cmp++;
        if (locked_out !== 1'b0) begin $display("FAIL rst_locked_out: got %b required 0", locked_out); n_fail++; end n_cmp++;
        if (fail_pulse !== 1'b0) begin $display("FAIL rst_fail_pulse: got %b required 0", fail_pulse); n_fail++; end n_cmp++;
        if (attempts_left !== 2'd3) begin $display("FAIL rst_attempts: got %0d required 3", attempts_left); n_fail++; end n_cmp++;
        if (entry_count !== 3'd0) begin $display("FAIL rst_count: got %0d required 0", entry_count); n_fail++; end n_cmp++;
        if (entry_buf !== 16'h0000) begin $display("FAIL rst_buf: got %h required 0000", entry_buf); n_fail++; end n_cmp++;
    endtask

    task automatic test_unlock();
        logic [15:0] exp_buf [4];
        exp_buf[0] = 16'h0001; exp_buf[1] = 16'h0021; exp_buf[2] = 16'h0321; exp_buf[3] = 16'h4321;
        load_secret = 1'b1; secret_in = 16'h4321;
        tick();
        load_secret = 1'b0;
        for (int i = 0; i < 4; i++) begin
            press(4'(i + 1));
            if (entry_count !== 3'(i + 1)) begin $display("FAIL unl_count%0d: got %0d required %0d", i, entry_count, i + 1); n_fail++; end n_cmp++;
            if (entry_buf !== exp_buf[i]) begin $display("FAIL unl_buf%0d: got %h required %h", i, entry_buf, exp_buf[i]); n_fail++; end n_cmp++;
            if (unlocked !== 1'b0) begin $display("FAIL unl_early%0d: got %b required 0", i, unlocked); n_fail++; end n_cmp++;
        end
        tick();
        if (unlocked !== 1'b1) begin $display("FAIL unl_hi: got %b required 1", unlocked); n_fail++; end n_cmp++;
        if (entry_count !== 3'd0) begin $display("FAIL unl_count_clr: got %0d required 0", entry_count); n_fail++; end n_cmp++;
        if (attempts_left !== 2'd3) begin $display("FAIL unl_attempts: got %0d required 3", attempts_left); n_fail++; end n_cmp++;
        if (fail_pulse !== 1'b0) begin $display("FAIL unl_fail: got %b required 0", fail_pulse); n_fail++; end n_cmp++;
        press(4'd5);
        if (entry_count !== 3'd0) begin $display("FAIL unl_ignore_digit: got %0d required 0", entry_count); n_fail++; end n_cmp++;
        if (unlocked !== 1'b1) begin $display("FAIL unl_hold: got %b required 1", unlocked); n_fail++; end n_cmp++;
        relock = 1'b1; tick(); relock = 1'b0;
        if (unlocked !== 1'b0) begin $display("FAIL unl_relock: got %b required 0", unlocked); n_fail++; end n_cmp++;
    endtask

    task automatic test_wrong_code();
        press(4'd1); press(4'd2); press(4'd3); press(4'd5);
        tick();
        if (fail_pulse !== 1'b1) begin $display("FAIL wrong_pulse: got %b required 1", fail_pulse); n_fail++; end n_cmp++;
        if (attempts_left !== 2'd2) begin $display("FAIL wrong_attempts: got %0d required 2", attempts_left); n_fail++; end n_cmp++;
        if (unlocked !== 1'b0) begin $display("FAIL wrong_unlocked: got %b required 0", unlocked); n_fail++; end n_cmp++;
        if (entry_count !== 3'd0) begin $display("FAIL wrong_count: got %0d required 0", entry_count); n_fail++; end n_cmp++;
        press(4'd1);
        if (fail_pulse !== 1'b0) begin $display("FAIL wrong_pulse_width: got %b required 0", fail_pulse); n_fail++; end n_cmp++;
        if (entry_count !== 3'd1) begin $display("FAIL wrong_back_entry: got %0d required 1", entry_count); n_fail++; end n_cmp++;
        press(4'd2); press(4'd3); press(4'd4);
        tick();
        if (unlocked !== 1'b1) begin $display("FAIL wrong_retry_unl: got %b required 1", unlocked); n_fail++; end n_cmp++;
        if (attempts_left !== 2'd3) begin $display("FAIL wrong_retry_att: got %0d required 3", attempts_left); n_fail++; end n_cmp++;
        relock = 1'b1; tick(); relock = 1'b0;
    endtask

    task automatic test_lockout();
        for (int k = 0; k < 3; k++) begin
            press(4'd1); press(4'd2); press(4'd3); press(4'd5);
            tick();
            if (fail_pulse !== 1'b1) begin $display("FAIL lo_pulse%0d: got %b required 1", k, fail_pulse); n_fail++; end n_cmp++;
            if (attempts_left !== 2'(2 - k)) begin $display("FAIL lo_att%0d: got %0d required %0d", k, attempts_left, 2 - k); n_fail++; end n_cmp++;
            if (locked_out !== (k == 2)) begin $display("FAIL lo_flag%0d: got %b required %b", k, locked_out, (k == 2)); n_fail++; end n_cmp++;
        end
        // First lockout cycle already observed; 7 more must stay high.
        for (int c = 1; c < 8; c++) begin
            clear = 1'b1; relock = 1'b1;
            press(4'd7);
            clear = 1'b0; relock = 1'b0;
            if (locked_out !== 1'b1) begin $display("FAIL lo_hold%0d: got %b required 1", c, locked_out); n_fail++; end n_cmp++;
            if (entry_count !== 3'd0) begin $display("FAIL lo_ignore%0d: got %0d required 0", c, entry_count); n_fail++; end n_cmp++;
            if (fail_pulse !== 1'b0) begin $display("FAIL lo_nopulse%0d: got %b required 0", c, fail_pulse); n_fail++; end n_cmp++;
        end
        press(4'd7);
        if (locked_out !== 1'b0) begin $display("FAIL lo_release: got %b required 0", locked_out); n_fail++; end n_cmp++;
        if (attempts_left !== 2'd3) begin $display("FAIL lo_att_restore: got %0d required 3", attempts_left); n_fail++; end n_cmp++;
        if (entry_count !== 3'd0) begin $display("FAIL lo_last_ignore: got %0d required 0", entry_count); n_fail++; end n_cmp++;
    endtask

    task automatic test_clear();
        press(4'd1); press(4'd2);
        clear = 1'b1; digit_valid = 1'b1; digit = 4'd3;
        tick();
        clear = 1'b0; digit_valid = 1'b0;
        if (entry_count !== 3'd0) begin $display("FAIL clr_count: got %0d required 0", entry_count); n_fail++; end n_cmp++;
        if (entry_buf !== 16'h0000) begin $display("FAIL clr_buf: got %h required 0000", entry_buf); n_fail++; end n_cmp++;
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        tick();
        if (unlocked !== 1'b1) begin $display("FAIL clr_unlock: got %b required 1", unlocked); n_fail++; end n_cmp++;
    endtask

    task automatic test_relock_load();
        relock = 1'b1; tick(); relock = 1'b0;
        if (unlocked !== 1'b0) begin $display("FAIL rl_relock: got %b required 0", unlocked); n_fail++; end n_cmp++;
        relock = 1'b1; press(4'd1); relock = 1'b0;
        if (entry_count !== 3'd1) begin $display("FAIL rl_relock_entry: got %0d required 1", entry_count); n_fail++; end n_cmp++;
        press(4'd2);
        load_secret = 1'b1; secret_in = 16'h9999; digit_valid = 1'b1; digit = 4'd3;
        tick();
        load_secret = 1'b0; digit_valid = 1'b0;
        if (entry_count !== 3'd0) begin $display("FAIL rl_load_count: got %0d required 0", entry_count); n_fail++; end n_cmp++;
        if (entry_buf !== 16'h0000) begin $display("FAIL rl_load_buf: got %h required 0000", entry_buf); n_fail++; end n_cmp++;
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        tick();
        if (fail_pulse !== 1'b1) begin $display("FAIL rl_old_fails: got %b required 1", fail_pulse); n_fail++; end n_cmp++;
        if (attempts_left !== 2'd2) begin $display("FAIL rl_old_att: got %0d required 2", attempts_left); n_fail++; end n_cmp++;
        press(4'd9); press(4'd9); press(4'd9); press(4'd9);
        tick();
        if (unlocked !== 1'b1) begin $display("FAIL rl_new_unlock: got %b required 1", unlocked); n_fail++; end n_cmp++;
        if (attempts_left !== 2'd3) begin $display("FAIL rl_new_att: got %0d required 3", attempts_left); n_fail++; end n_cmp++;
        load_secret = 1'b1; secret_in = 16'h4321; tick(); load_secret = 1'b0;
        if (unlocked !== 1'b0) begin $display("FAIL rl_load_drops_unl: got %b required 0", unlocked); n_fail++; end n_cmp++;
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) begin
            press(4'd8); press(4'd8); press(4'd8); press(4'd8);
            tick();
        end
        tick(); tick(); tick();
        if (locked_out !== 1'b1) begin $display("FAIL ar_pre_lock: got %b required 1", locked_out); n_fail++; end n_cmp++;
        // Mid-cycle assertion, checked before the next clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        if (locked_out !== 1'b0) begin $display("FAIL ar_locked_out: got %b required 0", locked_out); n_fail++; end n_cmp++;
        if (attempts_left !== 2'd3) begin $display("FAIL ar_attempts: got %0d required 3", attempts_left); n_fail++; end n_cmp++;
        if (fail_pulse !== 1'b0) begin $display("FAIL ar_fail: got %b required 0", fail_pulse); n_fail++; end n_cmp++;
        @(negedge clk);
        reset_n = 1'b1;
        press(4'd0);
        if (entry_count !== 3'd1) begin $display("FAIL ar_entry: got %0d required 1", entry_count); n_fail++; end n_cmp++;
        press(4'd0); press(4'd0); press(4'd0);
        tick();
        if (unlocked !== 1'b1) begin $display("FAIL ar_zero_secret: got %b required 1", unlocked); n_fail++; end n_cmp++;
    endtask

    initial begin
        reset_n     = 1'b0;
        digit_valid = 1'b0;
        digit       = 4'd0;
        clear       = 1'b0;
        load_secret = 1'b0;
        secret_in   = 16'h0000;
        relock      = 1'b0;
        tick(); tick();
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        test_reset();
        test_unlock();
        test_wrong_code();
        test_lockout();
        test_clear();
        test_relock_load();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
